// File: rtl/pll_lock_ce_gen_pkg.sv
// Shared types and default constants for the PLL lock qualifier and
// clock-enable generator.
package pll_lock_ce_gen_pkg;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_RUN    = 2'd3
    } state_t;

    // 72 MHz / 12 = 6 MHz fast enable
    localparam int unsigned CE_DIV_72M6     = 12;
    localparam int unsigned SETTLE_CYC_DEF  = 4096;
    localparam int unsigned FLUSH_CE_DEF    = 8;

    // The enable divider only runs in these states.
    function automatic logic is_active(input state_t s);
        return (s == ST_FLUSH) || (s == ST_RUN);
    endfunction

endpackage

// File: rtl/pll_lock_ce_gen_sync2.sv
// Generic two-flop synchroniser for asynchronous level flags.
// Ports: clk, reset (sync, active-high, clears both stages), d (async in),
// q (synchronised out, 2 clk cycles after d).
module pll_lock_ce_gen_sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_ce_gen.sv
// Qualifies the PLL lock flag, generates the ce_fast/ce_slow enables and
// sequences the core reset release.
// Ports: clk_sys (72 MHz), reset (sync, active-high), pll_locked (async),
// ce_fast/ce_slow (1-cycle strobes), core_reset, run, lock_loss_cnt[7:0].
module pll_lock_ce_gen
    import pll_lock_ce_gen_pkg::*;
#(
    parameter int unsigned CE_DIV     = CE_DIV_72M6,
    parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int unsigned FLUSH_CE   = FLUSH_CE_DEF
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       pll_locked,
    output logic       ce_fast,
    output logic       ce_slow,
    output logic       core_reset,
    output logic       run,
    output logic [7:0] lock_loss_cnt
);

    localparam logic [7:0]  DIV_LAST    = 8'(CE_DIV - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
    localparam logic [7:0]  FLUSH_LAST  = 8'(FLUSH_CE - 1);

    logic        lk;
    state_t      state;
    state_t      next_state;
    logic [15:0] settle_cnt;
    logic [7:0]  div_cnt;
    logic        ce_tog;
    logic [7:0]  flush_cnt;

    logic        keep_on;
    logic        ce_fast_d;
    logic        ce_slow_d;
    logic        core_reset_d;
    logic        run_d;
    logic        lost;

    pll_lock_ce_gen_sync2 #(
        .WIDTH (1)
    ) u_sync (
        .clk   (clk_sys),
        .reset (reset),
        .d     (pll_locked),
        .q     (lk)
    );

    // State register
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state <= ST_WAIT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; loss of lock has priority over any advance.
    always_comb begin
        next_state = state;
        unique case (state)
            ST_WAIT: begin
                if (lk) begin
                    next_state = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (!lk) begin
                    next_state = ST_WAIT;
                end else if (settle_cnt == SETTLE_LAST) begin
                    next_state = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (!lk) begin
                    next_state = ST_WAIT;
                end else if (ce_slow && flush_cnt == FLUSH_LAST) begin
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!lk) begin
                    next_state = ST_WAIT;
                end
            end
            default: next_state = ST_WAIT;
        endcase
    end

    // Output decode. Enables are computed from the next state so a lock
    // loss suppresses the strobe in the very cycle the FSM drops to WAIT.
    // keep_on is false on the SETTLE->FLUSH edge, which zeroes the divider
    // so the first ce_fast lands CE_DIV cycles into FLUSH.
    always_comb begin
        keep_on      = is_active(state) && is_active(next_state);
        ce_fast_d    = keep_on && (div_cnt == DIV_LAST);
        ce_slow_d    = ce_fast_d && ce_tog;
        core_reset_d = (next_state != ST_RUN);
        run_d        = (next_state == ST_RUN);
        lost         = !lk && (state != ST_WAIT);
    end

    // Counters
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            settle_cnt <= '0;
            div_cnt    <= '0;
            ce_tog     <= 1'b0;
            flush_cnt  <= '0;
        end else begin
            if (state == ST_SETTLE && next_state == ST_SETTLE) begin
                settle_cnt <= settle_cnt + 16'd1;
            end else begin
                settle_cnt <= '0;
            end

            if (!keep_on) begin
                div_cnt <= '0;
            end else if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 8'd1;
            end

            if (!keep_on) begin
                ce_tog <= 1'b0;
            end else if (ce_fast_d) begin
                ce_tog <= ~ce_tog;
            end

            if (state != ST_FLUSH || next_state != ST_FLUSH) begin
                flush_cnt <= '0;
            end else if (ce_slow) begin
                flush_cnt <= flush_cnt + 8'd1;
            end
        end
    end

    // Registered outputs
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ce_fast       <= 1'b0;
            ce_slow       <= 1'b0;
            core_reset    <= 1'b1;
            run           <= 1'b0;
            lock_loss_cnt <= '0;
        end else begin
            ce_fast    <= ce_fast_d;
            ce_slow    <= ce_slow_d;
            core_reset <= core_reset_d;
            run        <= run_d;
            if (lost && lock_loss_cnt != 8'hFF) begin
                lock_loss_cnt <= lock_loss_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pll_lock_ce_gen.sv
// Scoreboard bench for pll_lock_ce_gen with a short settle window.
// Expected output vectors are queued per cycle and popped as cycles elapse.
module tb_pll_lock_ce_gen;

    localparam int CE_DIV     = 12;
    localparam int SETTLE_CYC = 16;
    localparam int FLUSH_CE   = 2;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic       pll_locked;
    logic       ce_fast;
    logic       ce_slow;
    logic       core_reset;
    logic       run;
    logic [7:0] lock_loss_cnt;
    logic [11:0] obs;

    typedef struct {
        int          k;
        logic [11:0] v;
        string       tag;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_chk  = 0;
    int   n_pass = 0;

    localparam logic [11:0] V_RST = 12'b0010_0000_0000;

    always #5 clk_sys = ~clk_sys;

    assign obs = {ce_fast, ce_slow, core_reset, run, lock_loss_cnt};

    pll_lock_ce_gen #(
        .CE_DIV     (CE_DIV),
        .SETTLE_CYC (SETTLE_CYC),
        .FLUSH_CE   (FLUSH_CE)
    ) dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .pll_locked    (pll_locked),
        .ce_fast       (ce_fast),
        .ce_slow       (ce_slow),
        .core_reset    (core_reset),
        .run           (run),
        .lock_loss_cnt (lock_loss_cnt)
    );

    // Expected outputs k cycles after lock rises, FLUSH entered at k == f0.
    function automatic logic [11:0] exp_seq(int k, int f0, logic [7:0] loss);
        int   f;
        logic cf, cs, rn;
        f  = k - f0;
        cf = (f >= CE_DIV) && (f % CE_DIV == 0);
        cs = (f >= 2 * CE_DIV) && (f % (2 * CE_DIV) == 0);
        rn = (f >= 2 * CE_DIV * FLUSH_CE + 1);
        return {cf, cs, !rn, rn, loss};
    endfunction

    function automatic logic [11:0] v_wait(logic [7:0] loss);
        return {4'b0010, loss};
    endfunction

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        pll_locked = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        pll_locked = 1'b0;
        for (int k = 1; k <= 3; k++) sb.push_back('{k, V_RST, "reset"});
        for (int k = 1; k <= 3; k++) begin
            tick();
            while (sb.size() != 0 && sb[0].k == k) begin
                e = sb.pop_front();
                n_chk++;
                if (obs !== e.v)
                    $display("FAIL %s k=%0d got %h want %h", e.tag, k, obs, e.v);
                else
                    n_pass++;
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_lockup();
        do_reset();
        pll_locked = 1'b1;
        for (int k = 1; k <= 100; k++)
            sb.push_back('{k, exp_seq(k, 3 + SETTLE_CYC, 8'd0), "lockup"});
        for (int k = 1; k <= 100; k++) begin
            tick();
            while (sb.size() != 0 && sb[0].k == k) begin
                e = sb.pop_front();
                n_chk++;
                if (obs !== e.v)
                    $display("FAIL %s k=%0d got %h want %h", e.tag, k, obs, e.v);
                else
                    n_pass++;
            end
        end
    endtask

    task automatic test_glitch();
        do_reset();
        pll_locked = 1'b1;
        for (int k = 1; k <= 70; k++)
            sb.push_back('{k, exp_seq(k, 31, (k >= 14) ? 8'd1 : 8'd0), "glitch"});
        for (int k = 1; k <= 70; k++) begin
            tick();
            while (sb.size() != 0 && sb[0].k == k) begin
                e = sb.pop_front();
                n_chk++;
                if (obs !== e.v)
                    $display("FAIL %s k=%0d got %h want %h", e.tag, k, obs, e.v);
                else
                    n_pass++;
            end
            if (k == 11) pll_locked = 1'b0;
            if (k == 12) pll_locked = 1'b1;
        end
    endtask

    task automatic test_run_drop();
        do_reset();
        pll_locked = 1'b1;
        repeat (80) tick();
        pll_locked = 1'b0;
        for (int k = 1; k <= 20; k++)
            sb.push_back('{k, (k < 3) ? 12'b0001_0000_0000 : v_wait(8'd1),
                           "run_drop"});
        for (int k = 1; k <= 20; k++) begin
            tick();
            while (sb.size() != 0 && sb[0].k == k) begin
                e = sb.pop_front();
                n_chk++;
                if (obs !== e.v)
                    $display("FAIL %s k=%0d got %h want %h", e.tag, k, obs, e.v);
                else
                    n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
        pll_locked = 1'b1;
        for (int k = 1; k <= 30; k++)
            sb.push_back('{k, exp_seq(k, 19, 8'd0), "pre_flush"});
        sb.push_back('{31, V_RST, "mid_flush_rst"});
        for (int k = 32; k <= 131; k++)
            sb.push_back('{k, exp_seq(k - 31, 19, 8'd0), "reseq"});
        for (int k = 1; k <= 131; k++) begin
            tick();
            while (sb.size() != 0 && sb[0].k == k) begin
                e = sb.pop_front();
                n_chk++;
                if (obs !== e.v)
                    $display("FAIL %s k=%0d got %h want %h", e.tag, k, obs, e.v);
                else
                    n_pass++;
            end
            if (k == 30) reset = 1'b1;
            if (k == 31) reset = 1'b0;
        end
    endtask

    task automatic test_saturate();
        do_reset();
        pll_locked = 1'b1;
        sb.push_back('{8, v_wait(8'd1), "saturate"});
        for (int k = 1; k <= 260 * 8; k++) begin
            tick();
            while (sb.size() != 0 && sb[0].k == k) begin
                e = sb.pop_front();
                n_chk++;
                if (obs !== e.v)
                    $display("FAIL %s k=%0d got %h want %h", e.tag, k, obs, e.v);
                else
                    n_pass++;
            end
            pll_locked = ((k % 8) < 4);
            if (k % 8 == 0 && k < 260 * 8)
                sb.push_back('{k + 8,
                    v_wait(((k / 8 + 1) > 255) ? 8'd255 : 8'(k / 8 + 1)),
                    "saturate"});
        end
        reset = 1'b1;
        sb.push_back('{1, V_RST, "sat_clear"});
        for (int k = 1; k <= 1; k++) begin
            tick();
            while (sb.size() != 0 && sb[0].k == k) begin
                e = sb.pop_front();
                n_chk++;
                if (obs !== e.v)
                    $display("FAIL %s k=%0d got %h want %h", e.tag, k, obs, e.v);
                else
                    n_pass++;
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_loss_on_final_slow();
        do_reset();
        pll_locked = 1'b1;
        for (int k = 1; k <= 100; k++)
            sb.push_back('{k, (k <= 67) ? exp_seq(k, 19, 8'd0) : v_wait(8'd1),
                           "final_slow_loss"});
        for (int k = 1; k <= 100; k++) begin
            tick();
            while (sb.size() != 0 && sb[0].k == k) begin
                e = sb.pop_front();
                n_chk++;
                if (obs !== e.v)
                    $display("FAIL %s k=%0d got %h want %h", e.tag, k, obs, e.v);
                else
                    n_pass++;
            end
            if (k == 65) pll_locked = 1'b0;
        end
    endtask

    initial begin
        reset      = 1'b1;
        pll_locked = 1'b0;
        test_reset();
        test_lockup();
        test_glitch();
        test_run_drop();
        test_reset_mid_flush();
        test_saturate();
        test_loss_on_final_slow();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
